// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
package cpu_pkg;

    typedef enum logic [1:0] {
        PC4    = 2'b00,
        PCIMM  = 2'b01,
        IMMRS1 = 2'b10
    } branch_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_HOLD = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority select (CSR redirect, branch, jalr, PC+4)
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic        csr_redirect,
    input  logic [31:0] csr_target,
    input  logic [1:0]  branch_ctrl,
    input  logic [31:0] pc_imm_target,
    input  logic [31:0] rs1_imm_target,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);

    logic [31:0] rs1_aligned;
    logic [31:0] pc_plus4;

    assign rs1_aligned = rs1_imm_target & ~32'd1;
    assign pc_plus4    = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (csr_redirect) begin
            next_pc = csr_target;
        end else begin
            // Encoding 2'b11 is unused and falls back to sequential fetch.
            case (branch_ctrl_e'(branch_ctrl))
                PCIMM:   next_pc = pc_imm_target;
                IMMRS1:  next_pc = rs1_aligned;
                default: next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC, req/gnt/rvalid FSM, IF/ID word buffer
// Optional misaligned-target trap entry under IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic [1:0]  BranchCtrl,
    input  logic [31:0] pc_imm_target,
    input  logic [31:0] rs1_imm_target,
    input  logic        csr_redirect,
    input  logic [31:0] csr_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        IM_stall,
    output logic [31:0] if_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        if_misalign,
`endif
    output logic [31:0] if_instr
);

    import cpu_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;

    pc_next_mux u_pc_next_mux (
        .csr_redirect   (csr_redirect),
        .csr_target     (csr_target),
        .branch_ctrl    (BranchCtrl),
        .pc_imm_target  (pc_imm_target),
        .rs1_imm_target (rs1_imm_target),
        .pc             (pc_q),
        .next_pc        (next_pc)
    );

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign if_misalign = misalign_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        im_req  = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                im_req = 1'b1;
                if (im_gnt) begin
                    // A zero-wait memory may return data with the grant.
                    if (im_rvalid) begin
                        instr_d = im_rdata;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    instr_d = im_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCWrite) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
                    misalign_d = 1'b0;
                    // Misaligned target: keep the address for mepc, present a NOP.
                    if (next_pc[1]) begin
                        instr_d    = NOP_INSTR;
                        misalign_d = 1'b1;
                        state_d    = S_HOLD;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall depends on state only, so there is no combinational loop via PCWrite.
    assign IM_stall = (state_q != S_HOLD);
    assign im_addr  = pc_q;
    assign if_pc    = pc_q;
    assign if_instr = (state_q == S_HOLD) ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic [1:0]  BranchCtrl;
    logic [31:0] pc_imm_target;
    logic [31:0] rs1_imm_target;
    logic        csr_redirect;
    logic [31:0] csr_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        IM_stall;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PCWrite        (PCWrite),
        .BranchCtrl     (BranchCtrl),
        .pc_imm_target  (pc_imm_target),
        .rs1_imm_target (rs1_imm_target),
        .csr_redirect   (csr_redirect),
        .csr_target     (csr_target),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_gnt         (im_gnt),
        .im_rvalid      (im_rvalid),
        .im_rdata       (im_rdata),
        .IM_stall       (IM_stall),
        .if_pc          (if_pc),
`ifdef IF_MISALIGN_TRAP_EN
        .if_misalign    (if_misalign),
`endif
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle PCWrite pulse from S_HOLD; the fetch for the new PC must start next cycle.
    task automatic redirect(input logic csr, input logic [1:0] ctrl, input logic [31:0] exp_addr);
        PCWrite      = 1'b1;
        BranchCtrl   = ctrl;
        csr_redirect = csr;
        step();
        PCWrite      = 1'b0;
        BranchCtrl   = 2'b00;
        csr_redirect = 1'b0;
        check_eq("redir_req", {31'd0, im_req}, 32'd1);
        check_eq("redir_addr", im_addr, exp_addr);
        check_eq("redir_stall", {31'd0, IM_stall}, 32'd1);
        check_eq("redir_nop", if_instr, NOP);
    endtask

    // Serve the pending request: grant after gnt_delay cycles (spurious rvalid in the
    // first waiting cycle), data with the grant or one cycle later.
    task automatic serve(input logic [31:0] data, input int gnt_delay, input bit same_cycle,
                         input logic [31:0] exp_pc);
        for (int i = 0; i < gnt_delay; i++) begin
            im_rvalid = (i == 0);
            im_rdata  = 32'hBAD0_BAD0;
            step();
            check_eq("wait_req", {31'd0, im_req}, 32'd1);
            check_eq("wait_addr", im_addr, exp_pc);
            check_eq("wait_stall", {31'd0, IM_stall}, 32'd1);
        end
        im_gnt    = 1'b1;
        im_rvalid = same_cycle;
        im_rdata  = data;
        step();
        im_gnt    = 1'b0;
        if (!same_cycle) begin
            check_eq("gnt_req_drop", {31'd0, im_req}, 32'd0);
            check_eq("gnt_stall", {31'd0, IM_stall}, 32'd1);
            im_rvalid = 1'b1;
            step();
        end
        im_rvalid = 1'b0;
        im_rdata  = 32'h0;
        check_eq("hold_stall", {31'd0, IM_stall}, 32'd0);
        check_eq("hold_instr", if_instr, data);
        check_eq("hold_pc", if_pc, exp_pc);
    endtask

    initial begin
        rst_n          = 1'b0;
        PCWrite        = 1'b0;
        BranchCtrl     = 2'b00;
        pc_imm_target  = 32'h0;
        rs1_imm_target = 32'h0;
        csr_redirect   = 1'b0;
        csr_target     = 32'h0;
        im_gnt         = 1'b0;
        im_rvalid      = 1'b0;
        im_rdata       = 32'h0;

        step();
        step();
        check_eq("rst_req", {31'd0, im_req}, 32'd0);
        check_eq("rst_stall", {31'd0, IM_stall}, 32'd1);
        check_eq("rst_pc", if_pc, 32'h0);
        check_eq("rst_instr", if_instr, NOP);

        rst_n = 1'b1;
        step();
        check_eq("first_req", {31'd0, im_req}, 32'd1);
        check_eq("first_addr", im_addr, 32'h0);
        im_gnt = 1'b1;
        step();
        im_gnt = 1'b0;
        check_eq("first_wait_stall", {31'd0, IM_stall}, 32'd1);
        im_rvalid = 1'b1;
        im_rdata  = 32'hAAAA_0001;
        step();
        im_rvalid = 1'b0;
        check_eq("first_stall_3cyc", {31'd0, IM_stall}, 32'd0);
        check_eq("first_instr", if_instr, 32'hAAAA_0001);

        // Stalled hold: rvalid/branch inputs present but must be ignored.
        BranchCtrl    = 2'b01;
        pc_imm_target = 32'h0000_0800;
        for (int i = 0; i < 5; i++) begin
            im_rvalid = 1'b1;
            im_rdata  = 32'hDEAD_BEEF;
            step();
            check_eq("stall_pc", if_pc, 32'h0);
            check_eq("stall_instr", if_instr, 32'hAAAA_0001);
            check_eq("stall_req", {31'd0, im_req}, 32'd0);
            check_eq("stall_imstall", {31'd0, IM_stall}, 32'd0);
        end
        im_rvalid = 1'b0;

        redirect(1'b0, 2'b00, 32'h0000_0004);
        serve(32'h1111_0004, 0, 1'b1, 32'h0000_0004);

        pc_imm_target = 32'h0000_0200;
        redirect(1'b0, 2'b01, 32'h0000_0200);
        serve(32'h2222_0200, 4, 1'b0, 32'h0000_0200);

        rs1_imm_target = 32'h0000_0305;
        redirect(1'b0, 2'b10, 32'h0000_0304);
        serve(32'h3333_0304, 1, 1'b0, 32'h0000_0304);

        redirect(1'b0, 2'b11, 32'h0000_0308);
        serve(32'h4444_0308, 0, 1'b0, 32'h0000_0308);

        csr_target = 32'h0000_1000;
        pc_imm_target = 32'h0000_0200;
        redirect(1'b1, 2'b01, 32'h0000_1000);
        serve(32'h5555_1000, 0, 1'b1, 32'h0000_1000);

        csr_target = 32'hFFFF_FFFC;
        redirect(1'b1, 2'b00, 32'hFFFF_FFFC);
        serve(32'h6666_FFFC, 0, 1'b1, 32'hFFFF_FFFC);
        redirect(1'b0, 2'b00, 32'h0000_0000);
        serve(32'h7777_0000, 0, 1'b1, 32'h0000_0000);

`ifdef IF_MISALIGN_TRAP_EN
        pc_imm_target = 32'h0000_0102;
        PCWrite    = 1'b1;
        BranchCtrl = 2'b01;
        step();
        PCWrite    = 1'b0;
        BranchCtrl = 2'b00;
        check_eq("mis_req", {31'd0, im_req}, 32'd0);
        check_eq("mis_flag", {31'd0, if_misalign}, 32'd1);
        check_eq("mis_pc", if_pc, 32'h0000_0102);
        check_eq("mis_instr", if_instr, NOP);
        check_eq("mis_stall", {31'd0, IM_stall}, 32'd0);
        csr_target = 32'h0000_0000;
        redirect(1'b1, 2'b00, 32'h0000_0000);
        check_eq("mis_clear", {31'd0, if_misalign}, 32'd0);
        serve(32'h7777_0000, 0, 1'b1, 32'h0000_0000);
`endif

        // Asynchronous reset while waiting for data.
        redirect(1'b0, 2'b00, 32'h0000_0004);
        im_gnt = 1'b1;
        step();
        im_gnt = 1'b0;
        check_eq("pre_rst_pc", if_pc, 32'h0000_0004);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_req", {31'd0, im_req}, 32'd0);
        check_eq("async_rst_pc", if_pc, 32'h0);
        check_eq("async_rst_stall", {31'd0, IM_stall}, 32'd1);
        check_eq("async_rst_instr", if_instr, NOP);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
